// File: rtl/adma_desc_ctrl.sv
// ADMA2-style descriptor engine: fetches 64-bit descriptors from system memory,
// decodes NOP/TRAN/LINK actions and sequences the transfer block.
module adma_desc_ctrl #(
  parameter int unsigned DESC_STRIDE = 8,
  parameter int unsigned MAX_DESC    = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        adma_go,
  input  logic        adma_abort,
  input  logic [63:0] desc_base,
  input  logic        dir_in,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        start,
  output logic        direction,
  output logic [15:0] length,
  output logic [63:0] address_init,
  input  logic        transfer_done,
  output logic        busy,
  output logic        done,
  output logic        irq,
  output logic        error,
  output logic [63:0] err_ptr
);

  localparam int unsigned CW = $clog2(MAX_DESC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_XFER_START, S_XFER_WAIT, S_ERROR
  } state_t;

  state_t        state, state_next;
  logic [63:0]   desc_ptr;
  logic [63:0]   desc_word;
  logic [CW-1:0] desc_cnt;

  // Datapath strobes produced by the next-state logic
  logic ld_go, ld_word, ld_xfer, ptr_link, ptr_inc, set_err, clr_err, cnt_inc;

  // Descriptor fields of the most recently fetched word
  logic        d_valid, d_end, d_int;
  logic [1:0]  d_act;
  logic [15:0] d_len;
  logic [63:0] d_addr;

  assign d_valid = desc_word[0];
  assign d_end   = desc_word[1];
  assign d_int   = desc_word[2];
  assign d_act   = desc_word[5:4];
  assign d_len   = desc_word[31:16];
  assign d_addr  = {32'h0, desc_word[63:32]};

  assign mem_req  = (state == S_FETCH);
  assign mem_addr = desc_ptr;
  assign start    = (state == S_XFER_START);
  assign busy     = (state != S_IDLE);

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode, single-cycle pulses and datapath strobes
  always_comb begin
    state_next = state;
    done       = 1'b0;
    irq        = 1'b0;
    ld_go      = 1'b0;
    ld_word    = 1'b0;
    ld_xfer    = 1'b0;
    ptr_link   = 1'b0;
    ptr_inc    = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    cnt_inc    = 1'b0;
    // Abort takes priority over every in-run event and suppresses all pulses
    if (state != S_IDLE && adma_abort) begin
      state_next = S_IDLE;
      clr_err    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (adma_go) begin
            ld_go      = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            ld_word    = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!d_valid || desc_cnt == CW'(MAX_DESC)) begin
            set_err    = 1'b1;
            state_next = S_ERROR;
          end else begin
            cnt_inc = 1'b1;
            case (d_act)
              2'b10: begin
                ld_xfer    = 1'b1;
                state_next = S_XFER_START;
              end
              2'b11: begin
                ptr_link = 1'b1;
                if (d_end) begin
                  done       = 1'b1;
                  state_next = S_IDLE;
                end else begin
                  state_next = S_FETCH;
                end
              end
              default: begin
                if (d_end) begin
                  done       = 1'b1;
                  state_next = S_IDLE;
                end else begin
                  ptr_inc    = 1'b1;
                  state_next = S_FETCH;
                end
              end
            endcase
          end
        end
        S_XFER_START: state_next = S_XFER_WAIT;
        S_XFER_WAIT: begin
          if (transfer_done) begin
            irq = d_int;
            if (d_end) begin
              done       = 1'b1;
              state_next = S_IDLE;
            end else begin
              ptr_inc    = 1'b1;
              state_next = S_FETCH;
            end
          end
        end
        S_ERROR: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Descriptor pointer, latched descriptor, transfer outputs and error status
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      desc_ptr     <= '0;
      desc_word    <= '0;
      desc_cnt     <= '0;
      direction    <= 1'b1;
      length       <= '0;
      address_init <= '0;
      error        <= 1'b0;
      err_ptr      <= '0;
    end else begin
      if (ld_go) begin
        desc_ptr  <= desc_base;
        direction <= dir_in;
        error     <= 1'b0;
        desc_cnt  <= '0;
      end
      if (ld_word) desc_word <= mem_rdata;
      if (ld_xfer) begin
        length       <= d_len;
        address_init <= d_addr;
      end
      if (ptr_link) desc_ptr <= d_addr;
      if (ptr_inc)  desc_ptr <= desc_ptr + 64'(DESC_STRIDE);
      if (cnt_inc)  desc_cnt <= desc_cnt + 1'b1;
      if (set_err) begin
        error   <= 1'b1;
        err_ptr <= desc_ptr;
      end
      if (clr_err) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adma_desc_ctrl.sv
// Directed self-checking bench for adma_desc_ctrl (runaway guard shrunk to 4).
module tb_adma_desc_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        adma_go = 1'b0;
  logic        adma_abort = 1'b0;
  logic [63:0] desc_base = '0;
  logic        dir_in = 1'b0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        start;
  logic        direction;
  logic [15:0] length;
  logic [63:0] address_init;
  logic        transfer_done = 1'b0;
  logic        busy, done, irq, error;
  logic [63:0] err_ptr;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int irq_cnt = 0;
  int s0, d0, i0;

  localparam logic [1:0] NOP = 2'b00, TRAN = 2'b10, LINK = 2'b11;

  adma_desc_ctrl #(.DESC_STRIDE(8), .MAX_DESC(4)) dut (
    .CLK(CLK), .RESET(RESET), .adma_go(adma_go), .adma_abort(adma_abort),
    .desc_base(desc_base), .dir_in(dir_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .start(start), .direction(direction),
    .length(length), .address_init(address_init), .transfer_done(transfer_done),
    .busy(busy), .done(done), .irq(irq), .error(error), .err_ptr(err_ptr)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (start) start_cnt <= start_cnt + 1;
    if (done)  done_cnt  <= done_cnt + 1;
    if (irq)   irq_cnt   <= irq_cnt + 1;
  end

  function automatic logic [63:0] desc(input logic v, input logic e, input logic i,
                                       input logic [1:0] act, input logic [15:0] len,
                                       input logic [31:0] addr);
    return {addr, len, 10'b0, act, 1'b0, i, e, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [63:0] base, input logic dir, input string tag);
    adma_go = 1'b1; desc_base = base; dir_in = dir;
    @(negedge CLK);
    adma_go = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_req_lat"}, mem_req, 1);
  endtask

  task automatic fetch(input logic [63:0] a, input logic [63:0] d, input string tag);
    int unsigned n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_addr"}, mem_addr, a);
    mem_ack = 1'b1; mem_rdata = d;
    @(negedge CLK);
    mem_ack = 1'b0; mem_rdata = '0;
    chk({tag, "_req_drop"}, mem_req, 0);
  endtask

  // Entered in DECODE of a TRAN descriptor
  task automatic xfer(input logic [15:0] len, input logic [63:0] addr, input logic dir,
                      input logic intr, input logic last, input string tag);
    chk({tag, "_start_early"}, start, 0);
    @(negedge CLK);
    chk({tag, "_start"}, start, 1);
    chk({tag, "_length"}, length, len);
    chk({tag, "_addr_init"}, address_init, addr);
    chk({tag, "_dir"}, direction, dir);
    @(negedge CLK);
    chk({tag, "_start_1cyc"}, start, 0);
    chk({tag, "_wait_busy"}, busy, 1);
    @(negedge CLK);
    transfer_done = 1'b1;
    #1;
    chk({tag, "_irq"}, irq, intr);
    chk({tag, "_done"}, done, last);
    @(negedge CLK);
    transfer_done = 1'b0;
    chk({tag, "_busy_after"}, busy, !last);
    if (!last) chk({tag, "_next_req"}, mem_req, 1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_dir", direction, 1);
    chk("rst_len", length, 0);
    chk("rst_err", error, 0);
    chk("rst_errptr", err_ptr, 0);
    RESET = 1'b1;
    @(negedge CLK);

    // Single TRAN
    go(64'h100, 1'b1, "single");
    fetch(64'h100, desc(1, 1, 0, TRAN, 16'd3, 32'h0), "single");
    xfer(16'd3, 64'h0, 1'b1, 1'b0, 1'b1, "single");
    chk("single_starts", start_cnt, 1);

    // Chain of two TRANs, go while busy ignored
    go(64'h0, 1'b0, "chain");
    fetch(64'h0, desc(1, 0, 1, TRAN, 16'd5, 32'h4), "chain0");
    xfer(16'd5, 64'h4, 1'b0, 1'b1, 1'b0, "chain0");
    adma_go = 1'b1; desc_base = 64'h5000;
    @(negedge CLK);
    adma_go = 1'b0;
    fetch(64'h8, desc(1, 1, 0, TRAN, 16'd3, 32'h40), "chain1");
    xfer(16'd3, 64'h40, 1'b0, 1'b0, 1'b1, "chain1");
    chk("chain_starts", start_cnt, 3);
    chk("chain_irqs", irq_cnt, 1);

    // LINK
    go(64'h0, 1'b1, "link");
    fetch(64'h0, desc(1, 0, 0, LINK, 16'd0, 32'h200), "link0");
    chk("link_no_done", done, 0);
    s0 = start_cnt;
    fetch(64'h200, desc(1, 1, 0, TRAN, 16'd1, 32'h0), "link1");
    xfer(16'd1, 64'h0, 1'b1, 1'b0, 1'b1, "link1");
    chk("link_one_start", start_cnt - s0, 1);

    // Invalid descriptor at 0x8
    go(64'h0, 1'b0, "inv");
    fetch(64'h0, desc(1, 0, 0, TRAN, 16'd2, 32'h10), "inv0");
    xfer(16'd2, 64'h10, 1'b0, 1'b0, 1'b0, "inv0");
    fetch(64'h8, 64'h0, "inv1");
    s0 = start_cnt;
    @(negedge CLK);
    chk("inv_error", error, 1);
    chk("inv_errptr", err_ptr, 64'h8);
    chk("inv_busy_err", busy, 1);
    @(negedge CLK);
    chk("inv_busy_fall", busy, 0);
    chk("inv_sticky", error, 1);
    chk("inv_no_start", start_cnt - s0, 0);
    go(64'h300, 1'b1, "clr");
    chk("clr_error", error, 0);
    fetch(64'h300, desc(1, 1, 0, NOP, 16'd0, 32'h0), "clr");
    chk("nop_end_done", done, 1);
    @(negedge CLK);
    chk("nop_end_idle", busy, 0);

    // Runaway guard: fifth descriptor of a run errors
    go(64'h1000, 1'b0, "guard");
    for (int i = 0; i < 4; i++)
      fetch(64'h1000 + 64'(8 * i), desc(1, 0, 0, NOP, 16'd0, 32'h0), "guard_nop");
    fetch(64'h1020, desc(1, 0, 0, NOP, 16'd0, 32'h0), "guard_last");
    @(negedge CLK);
    chk("guard_error", error, 1);
    chk("guard_errptr", err_ptr, 64'h1020);
    @(negedge CLK);
    chk("guard_idle", busy, 0);

    // Abort in XFER_WAIT with late transfer_done
    go(64'h0, 1'b1, "abort");
    fetch(64'h0, desc(1, 1, 1, TRAN, 16'd7, 32'h80), "abort");
    @(negedge CLK);
    chk("abort_start", start, 1);
    @(negedge CLK);
    adma_abort = 1'b1;
    @(negedge CLK);
    adma_abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_error", error, 0);
    d0 = done_cnt; i0 = irq_cnt;
    transfer_done = 1'b1;
    #1;
    chk("late_td_done", done, 0);
    chk("late_td_irq", irq, 0);
    @(negedge CLK);
    transfer_done = 1'b0;
    chk("late_td_idle", busy, 0);
    chk("abort_no_pulses", (done_cnt - d0) + (irq_cnt - i0), 0);
    go(64'h400, 1'b0, "rerun");
    fetch(64'h400, desc(1, 1, 0, TRAN, 16'd0, 32'h1234), "rerun");
    xfer(16'd0, 64'h1234, 1'b0, 1'b0, 1'b1, "rerun");

    // Reset during FETCH, late mem_ack ignored
    go(64'h600, 1'b0, "rstmid");
    RESET = 1'b0;
    #1;
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_dir", direction, 1);
    chk("rstmid_len", length, 0);
    chk("rstmid_ainit", address_init, 0);
    @(negedge CLK);
    RESET = 1'b1;
    mem_ack = 1'b1; mem_rdata = desc(1, 1, 0, TRAN, 16'd9, 32'h9);
    @(negedge CLK);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("late_ack_busy", busy, 0);
    chk("late_ack_req", mem_req, 0);
    repeat (2) @(negedge CLK);
    chk("late_ack_start", start, 0);
    chk("late_ack_len", length, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
